// File: rtl/adc_capture_sequencer.sv
`default_nettype none
// ============================================================================
// adc_capture_sequencer : clk_usb-domain controller for N back-to-back ADC
// captures with trigger timeout, optional forced trigger and FIFO drain wait.
// Revision: 1.0
// ============================================================================
module adc_capture_sequencer #(
   parameter int pCOUNT_W   = 16,
   parameter int pTIMEOUT_W = 32
) (
   input  logic                  clk_usb,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [pCOUNT_W-1:0]   num_captures_i,
   input  logic [pTIMEOUT_W-1:0] timeout_i,
   input  logic                  force_on_timeout_i,
   input  logic                  drain_wait_i,
   input  logic                  armed_i,
   input  logic                  capture_go_i,
   input  logic                  fifo_empty_i,
   input  logic                  fifo_error_i,
   output logic                  cmd_arm_o,
   output logic                  trigger_now_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [pCOUNT_W-1:0]   capture_count_o,
   output logic [pCOUNT_W-1:0]   timeout_count_o
);

   localparam logic [pCOUNT_W-1:0] c_COUNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      WAIT_TRIG = 3'd2,
      WAIT_DONE = 3'd3,
      DRAIN     = 3'd4,
      ERROR     = 3'd5
   } state_t;

   state_t                  r_state;
   logic [2:0]              r_armed_pipe;   // [0] meta, [1] sync, [2] delayed
   logic [2:0]              r_capgo_pipe;
   logic [pCOUNT_W-1:0]     r_num;
   logic [pTIMEOUT_W-1:0]   r_timeout;
   logic                    r_force;
   logic                    r_drain;
   logic [pTIMEOUT_W-1:0]   r_timer;        // zero means not running

   logic                    w_armed_sync;
   logic                    w_cap_rise;
   logic                    w_cap_fall;
   logic                    w_active;
   logic [pCOUNT_W-1:0]     w_capture_next;
   logic [pCOUNT_W-1:0]     w_tcount_next;

   assign w_armed_sync   = r_armed_pipe[1];
   assign w_cap_rise     = r_capgo_pipe[1] & ~r_capgo_pipe[2];
   assign w_cap_fall     = ~r_capgo_pipe[1] & r_capgo_pipe[2];
   assign w_active       = (r_state == ARM) || (r_state == WAIT_TRIG) ||
                           (r_state == WAIT_DONE) || (r_state == DRAIN);
   assign w_capture_next = (capture_count_o == c_COUNT_MAX) ? capture_count_o
                                                            : capture_count_o + pCOUNT_W'(1);
   assign w_tcount_next  = (timeout_count_o == c_COUNT_MAX) ? timeout_count_o
                                                            : timeout_count_o + pCOUNT_W'(1);

   always_ff @(posedge clk_usb) begin
      if (reset) begin
         r_state         <= IDLE;
         r_armed_pipe    <= '0;
         r_capgo_pipe    <= '0;
         r_num           <= '0;
         r_timeout       <= '0;
         r_force         <= 1'b0;
         r_drain         <= 1'b0;
         r_timer         <= '0;
         cmd_arm_o       <= 1'b0;
         trigger_now_o   <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         error_o         <= 1'b0;
         capture_count_o <= '0;
         timeout_count_o <= '0;
      end else begin
         r_armed_pipe  <= {r_armed_pipe[1:0], armed_i};
         r_capgo_pipe  <= {r_capgo_pipe[1:0], capture_go_i};
         trigger_now_o <= 1'b0;
         done_o        <= 1'b0;

         if (abort_i) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            cmd_arm_o <= 1'b0;
            busy_o    <= 1'b0;
         end else if (fifo_error_i && w_active) begin
            r_state   <= ERROR;
            r_timer   <= '0;
            error_o   <= 1'b1;
            cmd_arm_o <= 1'b0;
            busy_o    <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start_i) begin
                     r_num           <= num_captures_i;
                     r_timeout       <= timeout_i;
                     r_force         <= force_on_timeout_i;
                     r_drain         <= drain_wait_i;
                     error_o         <= 1'b0;
                     capture_count_o <= '0;
                     timeout_count_o <= '0;
                     if (num_captures_i == '0) begin
                        done_o <= 1'b1;
                     end else begin
                        r_state   <= ARM;
                        cmd_arm_o <= 1'b1;
                        busy_o    <= 1'b1;
                     end
                  end
               end

               ARM: begin
                  if (w_armed_sync) begin
                     r_state <= WAIT_TRIG;
                     r_timer <= r_timeout;
                  end
               end

               // A capture edge beats a simultaneous expiry.
               WAIT_TRIG: begin
                  if (w_cap_rise) begin
                     r_state   <= WAIT_DONE;
                     r_timer   <= '0;
                     cmd_arm_o <= 1'b0;
                  end else if (r_timer == pTIMEOUT_W'(1)) begin
                     timeout_count_o <= w_tcount_next;
                     r_timer         <= '0;
                     if (r_force) begin
                        trigger_now_o <= 1'b1;
                     end else begin
                        r_state   <= ERROR;
                        error_o   <= 1'b1;
                        cmd_arm_o <= 1'b0;
                        busy_o    <= 1'b0;
                     end
                  end else if (r_timer != '0) begin
                     r_timer <= r_timer - pTIMEOUT_W'(1);
                  end
               end

               WAIT_DONE: begin
                  if (w_cap_fall) begin
                     capture_count_o <= w_capture_next;
                     if (w_capture_next == r_num) begin
                        r_state <= IDLE;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                     end else if (r_drain) begin
                        r_state <= DRAIN;
                     end else begin
                        r_state   <= ARM;
                        cmd_arm_o <= 1'b1;
                     end
                  end
               end

               DRAIN: begin
                  if (fifo_empty_i) begin
                     r_state   <= ARM;
                     cmd_arm_o <= 1'b1;
                  end
               end

               ERROR: begin
                  r_state <= IDLE;
               end

               default: begin
                  r_state   <= IDLE;
                  cmd_arm_o <= 1'b0;
                  busy_o    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_sequencer.sv
`default_nettype none
// ============================================================================
// tb_adc_capture_sequencer : table, hand-written and random checks of the
// capture sequencer against a trigger-unit/FIFO model.
// Revision: 1.0
// ============================================================================
module tb_adc_capture_sequencer;

   localparam int CW = 16;
   localparam int TW = 32;

   logic          clk_usb = 1'b0;
   logic          reset = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [CW-1:0] num_captures_i = '0;
   logic [TW-1:0] timeout_i = '0;
   logic          force_on_timeout_i = 1'b0;
   logic          drain_wait_i = 1'b0;
   logic          armed_i = 1'b0;
   logic          capture_go_i = 1'b0;
   logic          fifo_empty_i = 1'b1;
   logic          fifo_error_i = 1'b0;
   logic          cmd_arm_o, trigger_now_o, busy_o, done_o, error_o;
   logic [CW-1:0] capture_count_o, timeout_count_o;

   adc_capture_sequencer #(.pCOUNT_W(CW), .pTIMEOUT_W(TW)) dut (
      .clk_usb(clk_usb), .reset(reset), .start_i(start_i), .abort_i(abort_i),
      .num_captures_i(num_captures_i), .timeout_i(timeout_i),
      .force_on_timeout_i(force_on_timeout_i), .drain_wait_i(drain_wait_i),
      .armed_i(armed_i), .capture_go_i(capture_go_i), .fifo_empty_i(fifo_empty_i),
      .fifo_error_i(fifo_error_i), .cmd_arm_o(cmd_arm_o), .trigger_now_o(trigger_now_o),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .capture_count_o(capture_count_o), .timeout_count_o(timeout_count_o));

   always #5 clk_usb = ~clk_usb;

   int checks = 0;
   int errors = 0;

   // trigger unit / FIFO model knobs and observations
   int arm_dly = 4, cap_len = 20, trig_dly = 6, fifo_low = 0;
   bit drain_mode = 1'b0;
   int cyc = 0, done_cnt = 0, trig_cnt = 0, drain_viol = 0, trig_lat = 0;
   int tu_st = 0, tu_cnt = 0, fifo_cnt = 0, armed_at = 0;
   bit prev_arm = 1'b0, fifo_pending = 1'b0;

   typedef struct {
      int n; int tmo; bit frc; bit drn; int tdly; int flow;
      int e_cnt; int e_tcnt; bit e_err; int e_done; int e_trig;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_usb); #1;
   endtask

   // Trigger unit: arms arm_dly cycles after cmd_arm, triggers trig_dly later
   // (or on trigger_now), runs a cap_len capture; FIFO refills during capture.
   initial begin
      forever begin
         @(posedge clk_usb); #1;
         cyc++;
         if (done_o) done_cnt++;
         if (trigger_now_o) begin
            trig_cnt++;
            trig_lat = cyc - armed_at;
         end
         if (drain_mode && cmd_arm_o && !prev_arm && !fifo_empty_i) drain_viol++;
         prev_arm = cmd_arm_o;
         if (fifo_pending) begin
            if (fifo_cnt == 0) begin
               fifo_empty_i = 1'b1;
               fifo_pending = 1'b0;
            end else fifo_cnt--;
         end
         case (tu_st)
            0: if (cmd_arm_o) begin tu_cnt = 0; tu_st = 1; end
            1: if (!cmd_arm_o) tu_st = 0;
               else begin
                  tu_cnt++;
                  if (tu_cnt >= arm_dly) begin
                     armed_i = 1'b1; armed_at = cyc; tu_cnt = 0; tu_st = 2;
                  end
               end
            2: if (!cmd_arm_o) begin armed_i = 1'b0; tu_st = 0; end
               else begin
                  tu_cnt++;
                  if ((trig_dly >= 0 && tu_cnt >= trig_dly) || trigger_now_o) begin
                     armed_i = 1'b0; capture_go_i = 1'b1; fifo_empty_i = 1'b0;
                     fifo_pending = 1'b0; tu_cnt = 0; tu_st = 3;
                  end
               end
            default: begin
               tu_cnt++;
               if (tu_cnt >= cap_len) begin
                  capture_go_i = 1'b0; fifo_cnt = fifo_low; fifo_pending = 1'b1; tu_st = 0;
               end
            end
         endcase
      end
   end

   task automatic wait_quiet();
      for (int k = 0; k < 500 && !(fifo_empty_i && !capture_go_i); k++) tick();
   endtask

   task automatic pulse_start();
      start_i = 1'b1; tick(); start_i = 1'b0;
   endtask

   task automatic run_seq(input int n, input int tmo, input bit frc, input bit drn,
                          input int tdly, input int flow, input string tag);
      bit ended;
      wait_quiet();
      num_captures_i = CW'(n); timeout_i = TW'(tmo);
      force_on_timeout_i = frc; drain_wait_i = drn;
      trig_dly = tdly; fifo_low = flow; drain_mode = drn;
      done_cnt = 0; trig_cnt = 0; drain_viol = 0; trig_lat = 0;
      tick();
      pulse_start();
      ended = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         if (!busy_o) begin ended = 1'b1; break; end
         tick();
      end
      if (!ended) begin
         errors++;
         $display("FAIL %s_timeout actual=busy required=idle", tag);
      end
      repeat (4) tick();
   endtask

   function automatic void ref_model(input int n, input bit frc, input int tdly,
                                     output int cnt, output int tcnt, output bit err,
                                     output int dn, output int trg);
      if (n == 0) begin
         cnt = 0; tcnt = 0; err = 0; dn = 1; trg = 0;
      end else if (tdly >= 0) begin
         cnt = n; tcnt = 0; err = 0; dn = 1; trg = 0;
      end else if (frc) begin
         cnt = n; tcnt = n; err = 0; dn = 1; trg = n;
      end else begin
         cnt = 0; tcnt = 1; err = 1; dn = 0; trg = 0;
      end
   endfunction

   initial begin
      vecs[0] = '{3, 0,   0, 0,  6,  0, 3, 0, 0, 1, 0};
      vecs[1] = '{1, 100, 1, 0, -1,  0, 1, 1, 0, 1, 1};
      vecs[2] = '{1, 100, 0, 0, -1,  0, 0, 1, 1, 0, 0};
      vecs[3] = '{2, 0,   0, 1,  6, 50, 2, 0, 0, 1, 0};
      vecs[4] = '{0, 0,   0, 0,  6,  0, 0, 0, 0, 1, 0};
      vecs[5] = '{3, 50,  1, 0, -1,  0, 3, 3, 0, 1, 3};
      vecs[6] = '{2, 200, 0, 1, 10,  0, 2, 0, 0, 1, 0};

      repeat (3) tick();
      chk("rst_cmd_arm", cmd_arm_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      reset = 1'b0;
      tick();
      chk("rst_error", error_o, 0);
      chk("rst_trig_now", trigger_now_o, 0);
      chk("rst_cap_count", capture_count_o, 0);
      chk("rst_tmo_count", timeout_count_o, 0);

      // abort and start together in IDLE: no sequence
      num_captures_i = 3; timeout_i = 0;
      start_i = 1'b1; abort_i = 1'b1; tick(); start_i = 1'b0; abort_i = 1'b0;
      tick();
      chk("abort_start_busy", busy_o, 0);
      chk("abort_start_arm", cmd_arm_o, 0);

      for (int i = 0; i < 7; i++) begin
         run_seq(vecs[i].n, vecs[i].tmo, vecs[i].frc, vecs[i].drn,
                 vecs[i].tdly, vecs[i].flow, "vec");
         chk($sformatf("vec%0d_count", i), capture_count_o, vecs[i].e_cnt);
         chk($sformatf("vec%0d_tmo_count", i), timeout_count_o, vecs[i].e_tcnt);
         chk($sformatf("vec%0d_error", i), error_o, vecs[i].e_err);
         chk($sformatf("vec%0d_done_pulses", i), done_cnt, vecs[i].e_done);
         chk($sformatf("vec%0d_trig_pulses", i), trig_cnt, vecs[i].e_trig);
         chk($sformatf("vec%0d_cmd_arm", i), cmd_arm_o, 0);
         if (vecs[i].e_trig > 0)
            chk($sformatf("vec%0d_trig_latency", i), trig_lat, vecs[i].tmo + 3);
         if (vecs[i].drn)
            chk($sformatf("vec%0d_drain_rearm", i), drain_viol, 0);
      end

      // abort in WAIT_TRIG of capture 2 of 4
      wait_quiet();
      num_captures_i = 4; timeout_i = 0; force_on_timeout_i = 0; drain_wait_i = 0;
      trig_dly = 40; fifo_low = 0; drain_mode = 0; done_cnt = 0;
      pulse_start();
      for (int k = 0; k < 2000 && !(capture_count_o == 1 && cmd_arm_o); k++) tick();
      repeat (12) tick();
      chk("abort_pre_arm", cmd_arm_o, 1);
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      chk("abort_cmd_arm", cmd_arm_o, 0);
      chk("abort_busy", busy_o, 0);
      repeat (60) tick();
      chk("abort_count_held", capture_count_o, 1);
      chk("abort_no_done", done_cnt, 0);
      num_captures_i = 0;
      pulse_start();
      chk("abort_restart_clear", capture_count_o, 0);

      // FIFO error during WAIT_DONE, then zero-capture start clears it
      wait_quiet();
      num_captures_i = 2; trig_dly = 6; done_cnt = 0;
      pulse_start();
      for (int k = 0; k < 500 && !capture_go_i; k++) tick();
      repeat (6) tick();
      fifo_error_i = 1'b1; tick(); fifo_error_i = 1'b0;
      chk("ferr_error", error_o, 1);
      chk("ferr_busy", busy_o, 0);
      chk("ferr_cmd_arm", cmd_arm_o, 0);
      wait_quiet();
      repeat (5) tick();
      chk("ferr_sticky", error_o, 1);
      chk("ferr_no_done", done_cnt, 0);
      num_captures_i = 0;
      pulse_start();
      chk("ferr_clear_error", error_o, 0);
      chk("ferr_zero_done", done_o, 1);

      // reset mid-sequence drops arm on the same edge
      wait_quiet();
      num_captures_i = 2; trig_dly = 6;
      pulse_start();
      for (int k = 0; k < 2000 && !(capture_count_o == 1 && cmd_arm_o); k++) tick();
      repeat (5) tick();
      reset = 1'b1; tick();
      chk("midrst_cmd_arm", cmd_arm_o, 0);
      chk("midrst_count", capture_count_o, 0);
      reset = 1'b0; tick();

      // randomized configurations
      for (int r = 0; r < 12; r++) begin
         int n, tmo, tdly, mode, ecnt, etc, edn, etr;
         bit frc, drn, eerr;
         n    = $urandom_range(0, 4);
         mode = $urandom_range(0, 2);
         drn  = 1'($urandom_range(0, 1));
         if (mode == 0) begin
            tdly = $urandom_range(4, 30);
            tmo  = ($urandom_range(0, 1) == 0) ? 0 : tdly + $urandom_range(15, 100);
            frc  = 1'($urandom_range(0, 1));
         end else begin
            tdly = -1;
            tmo  = $urandom_range(1, 60);
            frc  = (mode == 1);
         end
         run_seq(n, tmo, frc, drn, tdly, $urandom_range(0, 40), "rand");
         ref_model(n, frc, tdly, ecnt, etc, eerr, edn, etr);
         chk($sformatf("rand%0d_count", r), capture_count_o, ecnt);
         chk($sformatf("rand%0d_tmo_count", r), timeout_count_o, etc);
         chk($sformatf("rand%0d_error", r), error_o, eerr);
         chk($sformatf("rand%0d_done_pulses", r), done_cnt, edn);
         chk($sformatf("rand%0d_trig_pulses", r), trig_cnt, etr);
         if (etr > 0) chk($sformatf("rand%0d_trig_latency", r), trig_lat, tmo + 3);
         if (drn) chk($sformatf("rand%0d_drain_rearm", r), drain_viol, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
